id_ex_skid: RTL and testbench



---
 rtl/id_ex_skid_if.sv | 62 ++++++
 rtl/id_ex_skid.sv | 155 +++++++++++++++
 tb/tb_id_ex_skid.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_skid_if.sv
// ID/EX stage bus: the producer (ID) side, the consumer (EX) side, the
// write-back snoop port and the flush strobe for id_ex_skid.
// The master modport is the environment (ID + EX + WB). The slave modport is the stage.
interface id_ex_skid_if #(
    parameter int INST_W   = 32,
    parameter int WORD_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUSEL_W = 3,
    parameter int ALUOP_W  = 8,
    parameter int MEMOP_W  = 2
) ();
    logic                         flush;

    logic                         id_valid;
    logic                         id_ready;
    logic [INST_W-1:0]            id_inst;
    logic [ALUSEL_W+ALUOP_W-1:0]  id_exop;
    logic [WORD_W-1:0]            id_srcLeft;
    logic [WORD_W-1:0]            id_srcRight;
    logic [REG_AW-1:0]            id_srcLeftAddr;
    logic [REG_AW-1:0]            id_srcRightAddr;
    logic                         id_srcLeftIsReg;
    logic                         id_srcRightIsReg;
    logic [REG_AW-1:0]            id_dest;

    logic                         wb_we;
    logic [REG_AW-1:0]            wb_addr;
    logic [WORD_W-1:0]            wb_data;

    logic                         ex_valid;
    logic                         ex_ready;
    logic [INST_W-1:0]            ex_inst;
    logic [ALUSEL_W-1:0]          ex_alusel;
    logic [ALUOP_W-1:0]           ex_aluop;
    logic [WORD_W-1:0]            ex_srcLeft;
    logic [WORD_W-1:0]            ex_srcRight;
    logic [REG_AW-1:0]            ex_dest;
    logic [MEMOP_W-1:0]           ex_memop;
    logic                         ex_writeEnable;

    modport master (
        output flush,
        output id_valid, id_inst, id_exop, id_srcLeft, id_srcRight,
        output id_srcLeftAddr, id_srcRightAddr, id_srcLeftIsReg, id_srcRightIsReg, id_dest,
        input  id_ready,
        output wb_we, wb_addr, wb_data,
        output ex_ready,
        input  ex_valid, ex_inst, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight,
        input  ex_dest, ex_memop, ex_writeEnable
    );

    modport slave (
        input  flush,
        input  id_valid, id_inst, id_exop, id_srcLeft, id_srcRight,
        input  id_srcLeftAddr, id_srcRightAddr, id_srcLeftIsReg, id_srcRightIsReg, id_dest,
        output id_ready,
        input  wb_we, wb_addr, wb_data,
        input  ex_ready,
        output ex_valid, ex_inst, ex_alusel, ex_aluop, ex_srcLeft, ex_srcRight,
        output ex_dest, ex_memop, ex_writeEnable
    );
endinterface

// File: rtl/id_ex_skid.sv
// ID/EX pipeline stage built as a two-entry skid buffer (head + skid) with
// valid/ready on both sides, synchronous flush and class decode at capture.
// Optional feature macro: ID_EX_FWD_EN -- when defined, a write-back that hits
// a held operand's source register overwrites that operand in place.
module id_ex_skid #(
    parameter int INST_W   = 32,
    parameter int WORD_W   = 32,
    parameter int REG_AW   = 5,
    parameter int ALUSEL_W = 3,
    parameter int ALUOP_W  = 8,
    parameter int MEMOP_W  = 2
) (
    input logic           clk,
    input logic           rst,
    id_ex_skid_if.slave   bus
);
    localparam int EXOP_W = ALUSEL_W + ALUOP_W;

    localparam logic [ALUSEL_W-1:0] EX_HIGH_SPECIAL  = ALUSEL_W'(0);
    localparam logic [ALUSEL_W-1:0] EX_HIGH_LOGIC    = ALUSEL_W'(1);
    localparam logic [ALUSEL_W-1:0] EX_HIGH_ARITH    = ALUSEL_W'(4);
    localparam logic [ALUOP_W-1:0]  EX_SPECIAL_NOP   = ALUOP_W'(0);
    localparam logic [MEMOP_W-1:0]  MEM_OP_NOP       = MEMOP_W'(0);
    localparam logic [MEMOP_W-1:0]  MEM_OP_WRITE_REG = MEMOP_W'(1);
    localparam logic [REG_AW-1:0]   REG_ZERO         = REG_AW'(0);

    typedef struct packed {
        logic [INST_W-1:0]   inst;
        logic [ALUSEL_W-1:0] alusel;
        logic [ALUOP_W-1:0]  aluop;
        logic [WORD_W-1:0]   src_left;
        logic [WORD_W-1:0]   src_right;
        logic [REG_AW-1:0]   left_addr;
        logic [REG_AW-1:0]   right_addr;
        logic                left_is_reg;
        logic                right_is_reg;
        logic [REG_AW-1:0]   dest;
        logic [MEMOP_W-1:0]  memop;
        logic                write_enable;
    } entry_t;

    logic   head_v, skid_v, ready_q;
    logic   head_v_n, skid_v_n;
    entry_t head, skid;
    entry_t head_n, skid_n;
    entry_t cap, head_cur, skid_cur;
    logic   in_fire, out_fire;
    logic   is_wr_class;

`ifdef ID_EX_FWD_EN
    function automatic entry_t fwd(input entry_t e, input logic we,
                                   input logic [REG_AW-1:0] addr,
                                   input logic [WORD_W-1:0] data);
        entry_t r;
        r = e;
        if (we && addr != REG_ZERO) begin
            if (e.left_is_reg && e.left_addr == addr)
                r.src_left = data;
            if (e.right_is_reg && e.right_addr == addr)
                r.src_right = data;
        end
        return r;
    endfunction
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.wb_we, bus.wb_addr, bus.wb_data,
                          head.left_addr, head.right_addr, head.left_is_reg, head.right_is_reg,
                          skid.left_addr, skid.right_addr, skid.left_is_reg, skid.right_is_reg};
`endif

    assign in_fire  = bus.id_valid && ready_q;
    assign out_fire = head_v && bus.ex_ready;

    // Decode the incoming instruction and refresh held operands against write-back.
    always_comb begin
        is_wr_class      = (bus.id_exop[EXOP_W-1:ALUOP_W] == EX_HIGH_LOGIC) ||
                           (bus.id_exop[EXOP_W-1:ALUOP_W] == EX_HIGH_ARITH);
        cap.inst         = bus.id_inst;
        cap.alusel       = bus.id_exop[EXOP_W-1:ALUOP_W];
        cap.aluop        = bus.id_exop[ALUOP_W-1:0];
        cap.src_left     = bus.id_srcLeft;
        cap.src_right    = bus.id_srcRight;
        cap.left_addr    = bus.id_srcLeftAddr;
        cap.right_addr   = bus.id_srcRightAddr;
        cap.left_is_reg  = bus.id_srcLeftIsReg;
        cap.right_is_reg = bus.id_srcRightIsReg;
        cap.dest         = bus.id_dest;
        cap.memop        = is_wr_class ? MEM_OP_WRITE_REG : MEM_OP_NOP;
        // r0 is never written, but the memory-stage op keeps its class meaning.
        cap.write_enable = is_wr_class && (bus.id_dest != REG_ZERO);
        head_cur         = head;
        skid_cur         = skid;
`ifdef ID_EX_FWD_EN
        cap      = fwd(cap,  bus.wb_we, bus.wb_addr, bus.wb_data);
        head_cur = fwd(head, bus.wb_we, bus.wb_addr, bus.wb_data);
        skid_cur = fwd(skid, bus.wb_we, bus.wb_addr, bus.wb_data);
`endif
    end

    // Next-entry steering: refill head when it is empty or leaving, else spill into skid.
    always_comb begin
        head_v_n = head_v;
        skid_v_n = skid_v;
        head_n   = head_cur;
        skid_n   = skid_cur;
        if (!head_v || out_fire) begin
            if (skid_v) begin
                head_n   = skid_cur;
                head_v_n = 1'b1;
                skid_n   = cap;
                skid_v_n = in_fire;
            end else begin
                head_n   = cap;
                head_v_n = in_fire;
            end
        end else if (in_fire) begin
            skid_n   = cap;
            skid_v_n = 1'b1;
        end
    end

    // Valid bits and registered ready; reset beats flush beats the handshakes.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b0;
        end else if (bus.flush) begin
            head_v  <= 1'b0;
            skid_v  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            head_v  <= head_v_n;
            skid_v  <= skid_v_n;
            ready_q <= !skid_v_n;
        end
    end

    // Entry payloads need no reset: they are only visible behind a valid bit.
    always_ff @(posedge clk) begin
        head <= head_n;
        skid <= skid_n;
    end

    assign bus.id_ready       = ready_q;
    assign bus.ex_valid       = head_v;
    assign bus.ex_inst        = head_v ? head.inst         : '0;
    assign bus.ex_alusel      = head_v ? head.alusel       : EX_HIGH_SPECIAL;
    assign bus.ex_aluop       = head_v ? head.aluop        : EX_SPECIAL_NOP;
    assign bus.ex_srcLeft     = head_v ? head.src_left     : '0;
    assign bus.ex_srcRight    = head_v ? head.src_right    : '0;
    assign bus.ex_dest        = head_v ? head.dest         : REG_ZERO;
    assign bus.ex_memop       = head_v ? head.memop        : MEM_OP_NOP;
    assign bus.ex_writeEnable = head_v ? head.write_enable : 1'b0;
endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: decode table, hand-written corner sequences and a
// randomized run, all checked against a queue-based FIFO model every cycle.
module tb_id_ex_skid;
    localparam logic [2:0] C_SPECIAL = 3'd0;
    localparam logic [2:0] C_LOGIC   = 3'd1;
    localparam logic [2:0] C_ARITH   = 3'd4;
    localparam logic [1:0] M_NOP     = 2'd0;
    localparam logic [1:0] M_WR      = 2'd1;

    logic clk = 1'b0;
    logic rst;

    id_ex_skid_if #(.INST_W(32), .WORD_W(32), .REG_AW(5), .ALUSEL_W(3), .ALUOP_W(8), .MEMOP_W(2)) bus ();

    id_ex_skid #(.INST_W(32), .WORD_W(32), .REG_AW(5), .ALUSEL_W(3), .ALUOP_W(8), .MEMOP_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  alusel;
        logic [7:0]  aluop;
        logic [31:0] sl;
        logic [31:0] sr;
        logic [4:0]  la;
        logic [4:0]  ra;
        logic        li;
        logic        ri;
        logic [4:0]  dest;
    } ent_t;

    typedef struct {
        logic [2:0] alusel;
        logic [4:0] dest;
        logic [1:0] memop;
        logic       we;
    } dvec_t;

    ent_t q[$];
    bit   m_ready = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model of one clock edge, using the inputs the DUT sees at that edge.
    task automatic model_edge();
        bit   in_f, out_f;
        ent_t c, t;
        in_f  = bus.id_valid && m_ready;
        out_f = (q.size() > 0) && bus.ex_ready;
        if (rst) begin
            q.delete();
            m_ready = 1'b0;
            return;
        end
        if (bus.flush) begin
            q.delete();
            m_ready = 1'b1;
            return;
        end
        c.inst   = bus.id_inst;
        c.alusel = bus.id_exop[10:8];
        c.aluop  = bus.id_exop[7:0];
        c.sl     = bus.id_srcLeft;
        c.sr     = bus.id_srcRight;
        c.la     = bus.id_srcLeftAddr;
        c.ra     = bus.id_srcRightAddr;
        c.li     = bus.id_srcLeftIsReg;
        c.ri     = bus.id_srcRightIsReg;
        c.dest   = bus.id_dest;
`ifdef ID_EX_FWD_EN
        if (bus.wb_we && bus.wb_addr != 5'd0) begin
            for (int i = 0; i < q.size(); i++) begin
                t = q[i];
                if (t.li && t.la == bus.wb_addr) t.sl = bus.wb_data;
                if (t.ri && t.ra == bus.wb_addr) t.sr = bus.wb_data;
                q[i] = t;
            end
            if (c.li && c.la == bus.wb_addr) c.sl = bus.wb_data;
            if (c.ri && c.ra == bus.wb_addr) c.sr = bus.wb_data;
        end
`endif
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(c);
        m_ready = (q.size() < 2);
    endtask

    task automatic compare_model();
        ent_t       h;
        bit         v;
        logic [1:0] em;
        logic       ew;
        v = (q.size() > 0);
        if (v) begin
            h  = q[0];
            em = (h.alusel == C_LOGIC || h.alusel == C_ARITH) ? M_WR : M_NOP;
            ew = (em == M_WR) && (h.dest != 5'd0);
        end else begin
            h  = '{default: '0};
            h.alusel = C_SPECIAL;
            em = M_NOP;
            ew = 1'b0;
        end
        chk("m_id_ready", 64'(bus.id_ready), 64'(m_ready));
        chk("m_ex_valid", 64'(bus.ex_valid), 64'(v));
        chk("m_ex_inst",  64'(bus.ex_inst),  64'(h.inst));
        chk("m_ex_alusel", 64'(bus.ex_alusel), 64'(h.alusel));
        chk("m_ex_aluop", 64'(bus.ex_aluop), 64'(h.aluop));
        chk("m_ex_srcLeft", 64'(bus.ex_srcLeft), 64'(h.sl));
        chk("m_ex_srcRight", 64'(bus.ex_srcRight), 64'(h.sr));
        chk("m_ex_dest", 64'(bus.ex_dest), 64'(h.dest));
        chk("m_ex_memop", 64'(bus.ex_memop), 64'(em));
        chk("m_ex_we", 64'(bus.ex_writeEnable), 64'(ew));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic idle();
        bus.flush            = 1'b0;
        bus.id_valid         = 1'b0;
        bus.id_inst          = '0;
        bus.id_exop          = '0;
        bus.id_srcLeft       = '0;
        bus.id_srcRight      = '0;
        bus.id_srcLeftAddr   = '0;
        bus.id_srcRightAddr  = '0;
        bus.id_srcLeftIsReg  = 1'b0;
        bus.id_srcRightIsReg = 1'b0;
        bus.id_dest          = '0;
        bus.wb_we            = 1'b0;
        bus.wb_addr          = '0;
        bus.wb_data          = '0;
        bus.ex_ready         = 1'b1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [2:0] cls, input logic [7:0] op,
                           input logic [31:0] sl, input logic [31:0] sr, input logic [4:0] dest,
                           input logic [4:0] ra, input logic ri);
        bus.id_valid         = 1'b1;
        bus.id_inst          = inst;
        bus.id_exop          = {cls, op};
        bus.id_srcLeft       = sl;
        bus.id_srcRight      = sr;
        bus.id_srcLeftAddr   = 5'd0;
        bus.id_srcRightAddr  = ra;
        bus.id_srcLeftIsReg  = 1'b0;
        bus.id_srcRightIsReg = ri;
        bus.id_dest          = dest;
    endtask

    dvec_t tbl[10];

    initial begin
        tbl[0] = '{C_ARITH,   5'd3,  M_WR,  1'b1};
        tbl[1] = '{C_LOGIC,   5'd5,  M_WR,  1'b1};
        tbl[2] = '{C_LOGIC,   5'd0,  M_WR,  1'b0};
        tbl[3] = '{C_ARITH,   5'd0,  M_WR,  1'b0};
        tbl[4] = '{C_SPECIAL, 5'd3,  M_NOP, 1'b0};
        tbl[5] = '{3'd2,      5'd7,  M_NOP, 1'b0};
        tbl[6] = '{3'd3,      5'd1,  M_NOP, 1'b0};
        tbl[7] = '{3'd5,      5'd9,  M_NOP, 1'b0};
        tbl[8] = '{3'd6,      5'd31, M_NOP, 1'b0};
        tbl[9] = '{3'd7,      5'd12, M_NOP, 1'b0};

        idle();
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_id_ready", 64'(bus.id_ready), 64'd0);
        chk("rst_ex_valid", 64'(bus.ex_valid), 64'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_id_ready", 64'(bus.id_ready), 64'd1);
        chk("post_rst_memop", 64'(bus.ex_memop), 64'(M_NOP));

        // single ARITH op: visible one cycle after fire, gone the next
        present(32'h0000_1111, C_ARITH, 8'h20, 32'h11, 32'h22, 5'd3, 5'd0, 1'b0);
        cyc();
        chk("arith_valid", 64'(bus.ex_valid), 64'd1);
        chk("arith_memop", 64'(bus.ex_memop), 64'(M_WR));
        chk("arith_we", 64'(bus.ex_writeEnable), 64'd1);
        chk("arith_srcLeft", 64'(bus.ex_srcLeft), 64'h11);
        idle();
        cyc();
        chk("arith_drop", 64'(bus.ex_valid), 64'd0);

        // decode table
        for (int i = 0; i < 10; i++) begin
            present(32'h100 + 32'(i), tbl[i].alusel, 8'(i), 32'(i), 32'(i * 3), tbl[i].dest, 5'd0, 1'b0);
            cyc();
            chk("tbl_valid", 64'(bus.ex_valid), 64'd1);
            chk("tbl_memop", 64'(bus.ex_memop), 64'(tbl[i].memop));
            chk("tbl_we", 64'(bus.ex_writeEnable), 64'(tbl[i].we));
            chk("tbl_inst", 64'(bus.ex_inst), 64'h100 + 64'(i));
            idle();
            cyc();
        end

        // LOGIC to r0 back-to-back with SPECIAL
        present(32'hA, C_LOGIC, 8'h1, 32'h1, 32'h2, 5'd0, 5'd0, 1'b0);
        cyc();
        chk("logic_r0_we", 64'(bus.ex_writeEnable), 64'd0);
        chk("logic_r0_memop", 64'(bus.ex_memop), 64'(M_WR));
        present(32'hB, C_SPECIAL, 8'h5, 32'h3, 32'h4, 5'd4, 5'd0, 1'b0);
        cyc();
        chk("special_we", 64'(bus.ex_writeEnable), 64'd0);
        chk("special_memop", 64'(bus.ex_memop), 64'(M_NOP));
        chk("special_inst", 64'(bus.ex_inst), 64'hB);
        idle();
        cyc();

        // streaming with backpressure
        present(32'hAAA, C_ARITH, 8'h1, 32'h1, 32'h1, 5'd1, 5'd0, 1'b0);
        cyc();
        present(32'hBBB, C_ARITH, 8'h2, 32'h2, 32'h2, 5'd2, 5'd0, 1'b0);
        cyc();
        chk("stream_b_head", 64'(bus.ex_inst), 64'hBBB);
        present(32'hCCC, C_ARITH, 8'h3, 32'h3, 32'h3, 5'd3, 5'd0, 1'b0);
        bus.ex_ready = 1'b0;
        cyc();
        chk("stream_b_held", 64'(bus.ex_inst), 64'hBBB);
        chk("stream_ready_low", 64'(bus.id_ready), 64'd0);
        idle();
        bus.ex_ready = 1'b0;
        cyc();
        chk("stream_still_b", 64'(bus.ex_inst), 64'hBBB);
        bus.ex_ready = 1'b1;
        cyc();
        chk("stream_c_next", 64'(bus.ex_inst), 64'hCCC);
        chk("stream_ready_back", 64'(bus.id_ready), 64'd1);
        cyc();
        chk("stream_empty", 64'(bus.ex_valid), 64'd0);

        // flush with two held entries and ID presenting
        bus.ex_ready = 1'b0;
        present(32'hF1, C_ARITH, 8'h0, 32'h0, 32'h0, 5'd1, 5'd0, 1'b0);
        cyc();
        present(32'hF2, C_ARITH, 8'h0, 32'h0, 32'h0, 5'd2, 5'd0, 1'b0);
        cyc();
        present(32'hF3, C_ARITH, 8'h0, 32'h0, 32'h0, 5'd3, 5'd0, 1'b0);
        bus.flush = 1'b1;
        cyc();
        chk("flush2_valid", 64'(bus.ex_valid), 64'd0);
        chk("flush2_inst", 64'(bus.ex_inst), 64'd0);
        chk("flush2_ready", 64'(bus.id_ready), 64'd1);
        idle();
        bus.ex_ready = 1'b0;
        cyc();
        chk("flush2_no_ghost", 64'(bus.ex_valid), 64'd0);
        // flush beating a real capture
        present(32'hE1, C_ARITH, 8'h0, 32'h0, 32'h0, 5'd1, 5'd0, 1'b0);
        cyc();
        present(32'hE2, C_ARITH, 8'h0, 32'h0, 32'h0, 5'd2, 5'd0, 1'b0);
        bus.flush = 1'b1;
        cyc();
        chk("flush1_valid", 64'(bus.ex_valid), 64'd0);
        idle();
        cyc();
        chk("flush1_no_ghost", 64'(bus.ex_valid), 64'd0);

        // write-back forwarding onto a held entry
        bus.ex_ready = 1'b0;
        present(32'hD1, C_ARITH, 8'h0, 32'h1, 32'h55, 5'd2, 5'd7, 1'b1);
        cyc();
        idle();
        bus.ex_ready = 1'b0;
        bus.wb_we = 1'b1;
        bus.wb_addr = 5'd7;
        bus.wb_data = 32'hDEADBEEF;
        cyc();
`ifdef ID_EX_FWD_EN
        chk("fwd_hit", 64'(bus.ex_srcRight), 64'hDEADBEEF);
`else
        chk("fwd_off", 64'(bus.ex_srcRight), 64'h55);
`endif
        idle();
        cyc();
        bus.ex_ready = 1'b0;
        present(32'hD2, C_ARITH, 8'h0, 32'h1, 32'h66, 5'd2, 5'd0, 1'b1);
        cyc();
        idle();
        bus.ex_ready = 1'b0;
        bus.wb_we = 1'b1;
        bus.wb_addr = 5'd0;
        bus.wb_data = 32'hDEADBEEF;
        cyc();
        chk("fwd_r0_ignored", 64'(bus.ex_srcRight), 64'h66);
        idle();
        cyc();

        // reset with both entries valid
        bus.ex_ready = 1'b0;
        present(32'hC1, C_LOGIC, 8'h0, 32'h0, 32'h0, 5'd1, 5'd0, 1'b0);
        cyc();
        present(32'hC2, C_LOGIC, 8'h0, 32'h0, 32'h0, 5'd2, 5'd0, 1'b0);
        cyc();
        rst = 1'b1;
        bus.flush = 1'b1;
        cyc();
        chk("midrst_valid", 64'(bus.ex_valid), 64'd0);
        chk("midrst_ready", 64'(bus.id_ready), 64'd0);
        chk("midrst_inst", 64'(bus.ex_inst), 64'd0);
        rst = 1'b0;
        idle();
        cyc();
        chk("midrst_ready_back", 64'(bus.id_ready), 64'd1);

        // randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            rst                  = ($urandom_range(0, 199) == 0);
            bus.flush            = ($urandom_range(0, 24) == 0);
            bus.id_valid         = ($urandom_range(0, 9) < 6);
            bus.id_inst          = $urandom;
            bus.id_exop          = 11'($urandom);
            bus.id_srcLeft       = $urandom;
            bus.id_srcRight      = $urandom;
            bus.id_srcLeftAddr   = 5'($urandom_range(0, 7));
            bus.id_srcRightAddr  = 5'($urandom_range(0, 7));
            bus.id_srcLeftIsReg  = 1'($urandom);
            bus.id_srcRightIsReg = 1'($urandom);
            bus.id_dest          = 5'($urandom_range(0, 3));
            bus.wb_we            = 1'($urandom);
            bus.wb_addr          = 5'($urandom_range(0, 7));
            bus.wb_data          = $urandom;
            bus.ex_ready         = ($urandom_range(0, 9) < 6);
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
